// File: rtl/pc_fetch_ctrl_pkg.sv
// pc_fetch_ctrl_pkg: shared constants and FSM state encoding for the fetch-stage PC unit
package pc_fetch_ctrl_pkg;
    localparam logic [31:0] DEF_RESET_PC = 32'hBFC0_0000;
    localparam logic [31:0] DEF_PC_STEP  = 32'd4;
    localparam logic [31:0] EXC_VECTOR   = 32'hBFC0_0380;
    typedef enum logic {SEQ = 1'b0, HOLD = 1'b1} fetch_state_t;
endpackage

// File: rtl/pc_fetch_ctrl.sv
// pc_fetch_ctrl: fetch-stage PC register, next-PC select, redirect buffering and imem request
//  clk, resetn (async active low)
//  stall_f, inst_addr_ok            : advance qualifiers
//  branch_d/taken_d/branch_target_d : ID-stage conditional branch
//  jump_d/jump_target_d             : ID-stage jump (wins over branch)
//  flush_exc/exc_target             : exception/ERET redirect
//  inst_req, pc_f, pc_plus4_f       : imem request and address
//  in_delayslot_f                   : instruction at pc_f is a delay slot
//  redirect_pending                 : a redirect is buffered waiting for fetch to advance
//  adel_f                           : misaligned fetch flag, only with PC_ALIGN_CHECK_EN defined
module pc_fetch_ctrl
    import pc_fetch_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC,
    parameter logic [31:0] PC_STEP  = DEF_PC_STEP
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        stall_f,
    input  logic        inst_addr_ok,
    input  logic        branch_d,
    input  logic        taken_d,
    input  logic [31:0] branch_target_d,
    input  logic        jump_d,
    input  logic [31:0] jump_target_d,
    input  logic        flush_exc,
    input  logic [31:0] exc_target,
`ifdef PC_ALIGN_CHECK_EN
    output logic        adel_f,
`endif
    output logic        inst_req,
    output logic [31:0] pc_f,
    output logic [31:0] pc_plus4_f,
    output logic        in_delayslot_f,
    output logic        redirect_pending
);
    fetch_state_t state_q, state_n;
    logic [31:0]  pc_n, pend_q, pend_n, redir_tgt;
    logic         started_q, ds_q, ds_n, redir, advance, req_raw;

    assign req_raw = started_q & ~flush_exc;
`ifdef PC_ALIGN_CHECK_EN
    // A misaligned PC raises adel_f and suppresses the request, so the PC freezes until an exception redirect
    assign adel_f   = (pc_f[1:0] != 2'b00) & req_raw;
    assign inst_req = req_raw & ~adel_f;
`else
    assign inst_req = req_raw;
`endif
    assign pc_plus4_f       = pc_f + PC_STEP;
    assign advance          = inst_req & inst_addr_ok & ~stall_f;
    assign redir            = (branch_d & taken_d) | jump_d;
    assign redir_tgt        = jump_d ? jump_target_d : branch_target_d;
    assign redirect_pending = state_q == HOLD;
    // The delay slot sits at pc_f while its branch/jump is in ID; stays flagged until that slot issues
    assign in_delayslot_f   = ds_q | branch_d | jump_d;
    assign ds_n             = (flush_exc | advance) ? 1'b0 : in_delayslot_f;

    always_comb begin
        state_n = state_q;
        pc_n    = pc_f;
        pend_n  = pend_q;
        if (flush_exc) begin
            pc_n    = exc_target;
            state_n = SEQ;
        end else if (state_q == HOLD) begin
            if (advance) begin
                pc_n    = pend_q;
                state_n = SEQ;
            end
        end else if (redir) begin
            if (advance) begin
                pc_n = redir_tgt;
            end else begin
                pend_n  = redir_tgt;
                state_n = HOLD;
            end
        end else if (advance) begin
            pc_n = pc_plus4_f;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= SEQ;
            pc_f      <= RESET_PC;
            pend_q    <= '0;
            ds_q      <= 1'b0;
            started_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            pc_f      <= pc_n;
            pend_q    <= pend_n;
            ds_q      <= ds_n;
            started_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb_pc_fetch_ctrl: directed self-checking bench for pc_fetch_ctrl
module tb_pc_fetch_ctrl;
    import pc_fetch_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        resetn, stall_f, inst_addr_ok, branch_d, taken_d, jump_d, flush_exc;
    logic [31:0] branch_target_d, jump_target_d, exc_target;
    logic        inst_req, in_delayslot_f, redirect_pending;
    logic [31:0] pc_f, pc_plus4_f;
`ifdef PC_ALIGN_CHECK_EN
    logic        adel_f;
`endif
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_fetch_ctrl dut (
        .clk(clk), .resetn(resetn), .stall_f(stall_f), .inst_addr_ok(inst_addr_ok),
        .branch_d(branch_d), .taken_d(taken_d), .branch_target_d(branch_target_d),
        .jump_d(jump_d), .jump_target_d(jump_target_d),
        .flush_exc(flush_exc), .exc_target(exc_target),
`ifdef PC_ALIGN_CHECK_EN
        .adel_f(adel_f),
`endif
        .inst_req(inst_req), .pc_f(pc_f), .pc_plus4_f(pc_plus4_f),
        .in_delayslot_f(in_delayslot_f), .redirect_pending(redirect_pending)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        branch_d = 1'b0; taken_d = 1'b0; jump_d = 1'b0; flush_exc = 1'b0;
    endtask

    initial begin
        resetn = 1'b0; stall_f = 1'b0; inst_addr_ok = 1'b1;
        idle();
        branch_target_d = '0; jump_target_d = '0; exc_target = '0;
        tick();
        chk("rst_pc", pc_f, 32'hBFC0_0000);
        chk("rst_req", inst_req, 0);
        chk("rst_ds", in_delayslot_f, 0);
        chk("rst_pend", redirect_pending, 0);
        resetn = 1'b1;
        tick();
        chk("first_req", inst_req, 1);
        chk("seq0", pc_f, 32'hBFC0_0000);
        tick();
        chk("seq1", pc_f, 32'hBFC0_0004);
        tick();
        chk("seq2", pc_f, 32'hBFC0_0008);
        chk("plus4", pc_plus4_f, 32'hBFC0_000C);
        // taken branch with advance
        branch_d = 1'b1; taken_d = 1'b1; branch_target_d = 32'hBFC0_0100;
        #1;
        chk("br_ds", in_delayslot_f, 1);
        tick();
        idle();
        chk("br_pc", pc_f, 32'hBFC0_0100);
        chk("br_pend", redirect_pending, 0);
        #1;
        chk("br_ds_clr", in_delayslot_f, 0);
        // taken branch under a 3-cycle stall
        stall_f = 1'b1; branch_d = 1'b1; taken_d = 1'b1; branch_target_d = 32'hBFC0_0200;
        tick();
        idle();
        chk("st_pend1", redirect_pending, 1);
        chk("st_pc1", pc_f, 32'hBFC0_0100);
        #1;
        chk("st_ds", in_delayslot_f, 1);
        tick();
        chk("st_pc2", pc_f, 32'hBFC0_0100);
        tick();
        chk("st_pc3", pc_f, 32'hBFC0_0100);
        chk("st_pend3", redirect_pending, 1);
        stall_f = 1'b0;
        tick();
        chk("st_rel_pc", pc_f, 32'hBFC0_0200);
        chk("st_rel_pend", redirect_pending, 0);
        chk("st_rel_ds", in_delayslot_f, 0);
        // exception beats a pending branch
        stall_f = 1'b1; branch_d = 1'b1; taken_d = 1'b1; branch_target_d = 32'hBFC0_0300;
        tick();
        idle();
        chk("ex_pend", redirect_pending, 1);
        flush_exc = 1'b1; exc_target = EXC_VECTOR;
        #1;
        chk("ex_req", inst_req, 0);
        tick();
        idle();
        stall_f = 1'b0;
        chk("ex_pc", pc_f, 32'hBFC0_0380);
        chk("ex_pend_clr", redirect_pending, 0);
        tick();
        chk("ex_next", pc_f, 32'hBFC0_0384);
        // not-taken branch stays sequential
        branch_d = 1'b1; taken_d = 1'b0; branch_target_d = 32'hBFC0_0500;
        #1;
        chk("nt_ds", in_delayslot_f, 1);
        tick();
        idle();
        chk("nt_pc", pc_f, 32'hBFC0_0388);
        chk("nt_pend", redirect_pending, 0);
        // not-taken branch under stall must not enter HOLD
        stall_f = 1'b1; branch_d = 1'b1; taken_d = 1'b0;
        tick();
        idle();
        stall_f = 1'b0;
        chk("nt_st_pend", redirect_pending, 0);
        tick();
        chk("nt_st_pc", pc_f, 32'hBFC0_038C);
        // jump wins over a taken branch
        branch_d = 1'b1; taken_d = 1'b1; branch_target_d = 32'hBFC0_0600;
        jump_d = 1'b1; jump_target_d = 32'hBFC0_0700;
        tick();
        idle();
        chk("jmp_pc", pc_f, 32'hBFC0_0700);
        // 32-bit wrap
        flush_exc = 1'b1; exc_target = 32'hFFFF_FFFC;
        tick();
        idle();
        chk("wrap_pc", pc_f, 32'hFFFF_FFFC);
        chk("wrap_plus4", pc_plus4_f, 32'h0000_0000);
        tick();
        chk("wrap_next", pc_f, 32'h0000_0000);
        // async reset in HOLD
        stall_f = 1'b1; branch_d = 1'b1; taken_d = 1'b1; branch_target_d = 32'hBFC0_0800;
        tick();
        idle();
        chk("ar_pend", redirect_pending, 1);
        #2;
        resetn = 1'b0;
        #1;
        chk("ar_pc", pc_f, 32'hBFC0_0000);
        chk("ar_pend_clr", redirect_pending, 0);
        chk("ar_req", inst_req, 0);
        stall_f = 1'b0;
        tick();
        resetn = 1'b1;
        tick();
        tick();
        chk("ar_seq", pc_f, 32'hBFC0_0004);
`ifdef PC_ALIGN_CHECK_EN
        jump_d = 1'b1; jump_target_d = 32'hBFC0_0102;
        tick();
        idle();
        chk("al_pc", pc_f, 32'hBFC0_0102);
        chk("al_adel", adel_f, 1);
        chk("al_req", inst_req, 0);
        tick();
        chk("al_hold", pc_f, 32'hBFC0_0102);
        flush_exc = 1'b1; exc_target = EXC_VECTOR;
        tick();
        idle();
        chk("al_flush_pc", pc_f, 32'hBFC0_0380);
        chk("al_adel_clr", adel_f, 0);
        chk("al_req_back", inst_req, 1);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
